shift_sub_divider: RTL

SHIFT_SUB_DIVIDER -- requirements
Module: shift_sub_divider

---
 rtl/shift_sub_divider_if.sv | 24 ++
 rtl/shift_sub_divider.sv | 125 ++++++++++++
 2 files changed

// File: rtl/shift_sub_divider_if.sv
// Request/result bundle for the shift-subtract divider.
// The requester drives start and operands; the divider returns status and results.
interface shift_sub_divider_if #(
    parameter int N = 8
);
    logic         start;
    logic [N-1:0] dividend;
    logic [N-1:0] divisor;
    logic         busy;
    logic         done;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;
    logic         div_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_zero
    );
endinterface

// File: rtl/shift_sub_divider.sv
// Unsigned restoring divider, one quotient bit per clock.
//
// state | meaning
// IDLE  | waiting for start; results of the last operation held
// CALC  | N restoring iterations, iteration counter counts down to 1
// DONE  | results valid, done pulses for this single cycle
//
// Visible results live in separate output registers so the working
// registers can churn during CALC without disturbing the user view.
module shift_sub_divider #(
    parameter int N = 8
) (
    input  logic                clk,
    input  logic                rst,
    shift_sub_divider_if.slave  bus
);
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;

    logic [N:0]    rem_r;
    logic [N-1:0]  quo_r;
    logic [N-1:0]  div_r;
    logic [CW-1:0] cnt_r;

    logic [N-1:0]  quo_out;
    logic [N-1:0]  rem_out;
    logic          dz_out;

    logic [N+1:0]  shl;
    logic [N:0]    diff;
    logic          ge;
    logic [N:0]    rem_nxt;
    logic [N-1:0]  quo_nxt;
    logic          last_iter;
    logic          accept;

    assign last_iter = (cnt_r == CW'(1));
    assign accept    = (state == IDLE) && bus.start;

    // One restoring step: shift {R,Q}, trial-subtract D, keep or restore.
    // A set bit shifted out of R means the partial value certainly exceeds D.
    always_comb begin
        shl     = {rem_r, quo_r[N-1]};
        diff    = shl[N:0] - {1'b0, div_r};
        ge      = shl[N+1] | (shl[N:0] >= {1'b0, div_r});
        rem_nxt = ge ? diff : shl[N:0];
        quo_nxt = {quo_r[N-2:0], ge};
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; a zero divisor bypasses CALC entirely.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nxt = (bus.divisor == '0) ? DONE : CALC;
                end
            end
            CALC: begin
                if (last_iter) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Working registers, iteration counter and user-visible result registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rem_r   <= '0;
            quo_r   <= '0;
            div_r   <= '0;
            cnt_r   <= '0;
            quo_out <= '0;
            rem_out <= '0;
            dz_out  <= 1'b0;
        end else if (accept) begin
            if (bus.divisor != '0) begin
                rem_r <= '0;
                quo_r <= bus.dividend;
                div_r <= bus.divisor;
                cnt_r <= CW'(N);
            end else begin
                quo_out <= '1;
                rem_out <= bus.dividend;
                dz_out  <= 1'b1;
            end
        end else if (state == CALC) begin
            rem_r <= rem_nxt;
            quo_r <= quo_nxt;
            cnt_r <= cnt_r - CW'(1);
            if (last_iter) begin
                quo_out <= quo_nxt;
                rem_out <= rem_nxt[N-1:0];
                dz_out  <= 1'b0;
            end
        end
    end

    assign bus.busy      = (state == CALC);
    assign bus.done      = (state == DONE);
    assign bus.quotient  = quo_out;
    assign bus.remainder = rem_out;
    assign bus.div_zero  = dz_out;

endmodule
